// File: rtl/class_vote_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : class_vote_pkg                                         |
// | Description : Shared types and constants for the class vote display: |
// |               FSM state encoding, class/vote widths and the hex      |
// |               seven-segment lookup table (bit0 = segment a).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package class_vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int CLASS_W     = 4;
  localparam int NUM_CLASSES = 16;
  // Vote counters never exceed 15 because the sample count is bounded.
  localparam int VOTE_W      = 4;

  // Active-high segments, bit order g f e d c b a.
  localparam logic [6:0] SEG_LUT [NUM_CLASSES] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seg7_hex_decoder                                       |
// | Description : Purely combinational 4-bit hex to 7-segment decode.    |
// |               The parent registers the result.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seg7_hex_decoder
  import class_vote_pkg::*;
(
  input  logic [CLASS_W-1:0] hex,
  output logic [6:0]         seg
);

  // Table lookup covering digits 0-9 and letters A-F
  always_comb begin
    seg = SEG_LUT[hex];
  end

endmodule
`default_nettype wire

// File: rtl/class_vote_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : class_vote_display                                     |
// | Description : Collects N_SAMPLES classifier outputs, majority-votes  |
// |               the perceptron class (lowest index wins ties), shows   |
// |               it on a 7-segment display for MAX_COUNT cycles and     |
// |               lights the decimal point on majority disagreement.     |
// |               Optional macro CLASS_VOTE_BNN_EN: the bnn class also   |
// |               casts a vote for every accepted sample.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module class_vote_display
  import class_vote_pkg::*;
#(
  parameter int               CNT_W     = 24,
  parameter logic [CNT_W-1:0] MAX_COUNT = 24'd10_000_000,
  parameter int               N_SAMPLES = 4
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               sample_valid,
  input  logic [CLASS_W-1:0] perc_class,
  input  logic [CLASS_W-1:0] bnn_class,
  output logic [6:0]         seg_out,
  output logic               dp_out,
  output logic [CLASS_W-1:0] result,
  output logic               result_valid,
  output logic               busy
);

  localparam logic [VOTE_W-1:0] c_n_samples = VOTE_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0]  c_hold_load = MAX_COUNT - CNT_W'(1);

  state_t              r_state;
  logic [VOTE_W-1:0]   r_vote [NUM_CLASSES];
  logic [VOTE_W-1:0]   r_count;
  logic [VOTE_W-1:0]   r_disagree;
  logic [CNT_W-1:0]    r_timer;
  logic [CLASS_W-1:0]  r_result;
  logic                r_dp;
  logic                r_valid;
  logic                r_busy;
  logic [6:0]          r_seg;

  logic                w_accept;
  logic                w_last;
  logic                w_dp_next;
  logic [1:0]          w_inc [NUM_CLASSES];
  logic [CLASS_W-1:0]  w_best_idx;
  logic [6:0]          w_seg_next;

  assign w_accept  = ena & sample_valid & ((r_state == IDLE) | (r_state == COLLECT));
  assign w_last    = w_accept & ((r_count + VOTE_W'(1)) == c_n_samples);
  assign w_dp_next = {r_disagree, 1'b0} > 5'(N_SAMPLES);

  // Per-class vote increment for the sample currently offered
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_vote_inc
`ifdef CLASS_VOTE_BNN_EN
      assign w_inc[gi] = {1'b0, perc_class == CLASS_W'(gi)}
                       + {1'b0, bnn_class  == CLASS_W'(gi)};
`else
      assign w_inc[gi] = {1'b0, perc_class == CLASS_W'(gi)};
`endif
    end
  endgenerate

  // Pairwise max tree; the left (lower index) side wins unless the right is strictly larger
  always_comb begin
    logic [VOTE_W-1:0]  t_cnt [NUM_CLASSES];
    logic [CLASS_W-1:0] t_idx [NUM_CLASSES];
    for (int i = 0; i < NUM_CLASSES; i++) begin
      t_cnt[i] = r_vote[i];
      t_idx[i] = CLASS_W'(i);
    end
    for (int w = NUM_CLASSES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        if (t_cnt[2*j+1] > t_cnt[2*j]) begin
          t_cnt[j] = t_cnt[2*j+1];
          t_idx[j] = t_idx[2*j+1];
        end else begin
          t_cnt[j] = t_cnt[2*j];
          t_idx[j] = t_idx[2*j];
        end
      end
    end
    w_best_idx = t_idx[0];
  end

  seg7_hex_decoder u_seg_dec (
    .hex (w_best_idx),
    .seg (w_seg_next)
  );

  // Control FSM, vote bookkeeping and registered display outputs; ena low freezes everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) r_vote[i] <= '0;
      r_count    <= '0;
      r_disagree <= '0;
      r_timer    <= '0;
      r_result   <= '0;
      r_dp       <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_seg      <= '0;
    end else if (ena) begin
      case (r_state)
        IDLE, COLLECT: begin
          if (w_accept) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_vote[i] <= r_vote[i] + VOTE_W'(w_inc[i]);
            r_count <= r_count + VOTE_W'(1);
            if (perc_class != bnn_class) r_disagree <= r_disagree + VOTE_W'(1);
            if (w_last) begin
              r_state <= DECIDE;
              r_busy  <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end
        end
        DECIDE: begin
          r_result <= w_best_idx;
          r_seg    <= w_seg_next;
          r_dp     <= w_dp_next;
          r_timer  <= c_hold_load;
          r_valid  <= 1'b1;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (r_timer == '0) begin
            r_state    <= IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) r_vote[i] <= '0;
            r_count    <= '0;
            r_disagree <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign seg_out      = r_seg;
  assign dp_out       = r_dp;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_class_vote_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_class_vote_display                                  |
// | Description : Randomised scoreboard bench for class_vote_display.    |
// |               Honours CLASS_VOTE_BNN_EN in its reference model.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_class_vote_display;

  localparam int N_SAMPLES = 4;
  localparam int MAX_COUNT = 8;
  localparam int FREEZE    = 5;
  localparam int LIMIT     = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] perc_class = '0;
  logic [3:0] bnn_class = '0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] result;
  logic       result_valid;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [3:0] res;
    logic [6:0] seg;
    logic       dp;
    int         hold;
    int         rise;
  } exp_t;

  exp_t sb[$];

  class_vote_display #(
    .CNT_W     (24),
    .MAX_COUNT (24'(MAX_COUNT)),
    .N_SAMPLES (N_SAMPLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_valid (sample_valid),
    .perc_class   (perc_class),
    .bnn_class    (bnn_class),
    .seg_out      (seg_out),
    .dp_out       (dp_out),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference: tally votes, take the most frequent class (first one on a tie)
  function automatic exp_t model(input logic [15:0] pv, input logic [15:0] bv,
                                 input int hold, input int rise);
    int   votes [16];
    int   dis;
    int   best;
    exp_t e;
    dis = 0;
    for (int c = 0; c < 16; c++) votes[c] = 0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      votes[pv[4*k +: 4]]++;
`ifdef CLASS_VOTE_BNN_EN
      votes[bv[4*k +: 4]]++;
`endif
      if (pv[4*k +: 4] != bv[4*k +: 4]) dis++;
    end
    best = 0;
    for (int c = 1; c < 16; c++) if (votes[c] > votes[best]) best = c;
    e.res  = 4'(best);
    e.seg  = ref_seg(4'(best));
    e.dp   = (2 * dis > N_SAMPLES);
    e.hold = hold;
    e.rise = rise;
    return e;
  endfunction

  // Offers N_SAMPLES samples with random idle/frozen gaps, then drives junk while busy
  task automatic run_decision(input logic [15:0] pv, input logic [15:0] bv,
                              input bit freeze, input bit junk);
    int guard;
    int seen;
    bit froze;
    for (int k = 0; k < N_SAMPLES; k++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 0) begin
          ena = 1'b1; sample_valid = 1'b0;
        end else begin
          ena = 1'b0; sample_valid = 1'b1;
          perc_class = 4'($urandom); bnn_class = 4'($urandom);
        end
        @(posedge clk); #1;
      end
      ena = 1'b1; sample_valid = 1'b1;
      perc_class = pv[4*k +: 4];
      bnn_class  = bv[4*k +: 4];
      if (k == N_SAMPLES - 1)
        sb.push_back(model(pv, bv, MAX_COUNT + (freeze ? FREEZE : 0), edge_cnt + 2));
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    guard = 0; seen = 0; froze = 1'b0;
    while (busy !== 1'b0 && guard < LIMIT) begin
      if (junk) begin
        sample_valid = 1'b1;
        perc_class = 4'($urandom); bnn_class = 4'($urandom);
      end else begin
        sample_valid = 1'b0;
      end
      if (freeze && !froze && result_valid === 1'b1) begin
        seen++;
        if (seen == 2) begin
          ena = 1'b0;
          repeat (FREEZE) begin @(posedge clk); #1; end
          ena = 1'b1;
          froze = 1'b1;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    sample_valid = 1'b0;
    if (guard >= LIMIT) begin
      vectors++; miscompares++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, LIMIT);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_seg"},    32'(seg_out), 32'h0);
    check({tag, "_dp"},     32'(dp_out), 32'h0);
    check({tag, "_result"}, 32'(result), 32'h0);
    check({tag, "_rv"},     32'(result_valid), 32'h0);
    check({tag, "_busy"},   32'(busy), 32'h0);
  endtask

  // Monitor: pops an expectation on each result_valid rise and times the hold window
  initial begin
    exp_t e;
    bit   prev;
    bit   active;
    int   len;
    prev = 1'b0; active = 1'b0; len = 0;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && !prev) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(result_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("result",     32'(result), 32'(e.res));
          check("seg_out",    32'(seg_out), 32'(e.seg));
          check("dp_out",     32'(dp_out), 32'(e.dp));
          check("busy_hold",  32'(busy), 32'h1);
          check("latency",    32'(edge_cnt), 32'(e.rise));
          len = 1; active = 1'b1;
        end
      end else if (result_valid === 1'b1 && active) begin
        len++;
      end else if (result_valid !== 1'b1 && prev && active) begin
        check("hold_len",  32'(len), 32'(e.hold));
        check("busy_idle", 32'(busy), 32'h0);
        check("seg_kept",  32'(seg_out), 32'(e.seg));
        active = 1'b0;
      end
      prev = (result_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pv;
    logic [15:0] bv;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_state("reset");
    rst_n = 1'b1; ena = 1'b1;

    run_decision(16'h7777, 16'h7777, 1'b0, 1'b0);
    run_decision(16'h5353, 16'h5353, 1'b0, 1'b0);
    run_decision(16'h9929, 16'h9929, 1'b0, 1'b1);
    run_decision(16'h1111, 16'h4441, 1'b0, 1'b1);

    // Two samples, then reset: the partial collect must be discarded
    ena = 1'b1; sample_valid = 1'b1; perc_class = 4'h0; bnn_class = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
    sample_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midreset");
    rst_n = 1'b1;
    run_decision(16'h5353, 16'h5353, 1'b0, 1'b0);

    run_decision(16'h1111, 16'h4411, 1'b1, 1'b1);
    run_decision(16'h6622, 16'h2666, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        pv[4*k +: 4] = (n % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        bv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? pv[4*k +: 4] : 4'($urandom_range(0, 15));
      end
      run_decision(pv, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
